sample_capture: RTL and testbench

- Consumer end of the sample-rate strobe interface. Sampling control drives the `Enable` strobe at a 10^Mode decimation of `Fg_CLK`.
- This block stores one DDS output sample per `Enable` strobe into an internal buffer. When the buffer is full it signals `Ready`, and a downstream reader (display/UART path) drains the buffer with a read handshake.
- Sits between the DDS output datapath and the readout logic.

---
 rtl/sample_capture_pkg.sv | 19 +
 rtl/sample_capture_ram.sv | 34 +++
 rtl/sample_capture.sv | 148 ++++++++++++++
 tb/tb_sample_capture.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sample_capture_pkg.sv
// Shared types and defaults for the sample capture buffer.
// SAMPLE_CAPTURE_TRIGGER_EN adds the ARMED state used by the level trigger.
package sample_capture_pkg;

  localparam int DEF_DW    = 8;
  localparam int DEF_DEPTH = 256;
  localparam int MODE_MAX  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READOUT = 2'd2
`ifdef SAMPLE_CAPTURE_TRIGGER_EN
    ,
    ST_ARMED   = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/sample_capture_ram.sv
// Simple dual-port sample RAM: one write port and one registered read port.
// The read data register resets to 0 and holds its value between reads.
module sample_capture_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sample_capture.sv
// Captures DEPTH strobed samples after Arm, then drains them through a read handshake.
// Define SAMPLE_CAPTURE_TRIGGER_EN to add Trig_Level and the rising-level ARMED state.
module sample_capture
  import sample_capture_pkg::*;
#(
  parameter  int DW    = DEF_DW,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          Fg_CLK,
  input  logic          RESET,
  input  logic          Enable,
  input  logic [DW-1:0] Sample,
  input  logic [3:0]    Mode,
  input  logic          Arm,
  input  logic          Rd_En,
`ifdef SAMPLE_CAPTURE_TRIGGER_EN
  input  logic [DW-1:0] Trig_Level,
`endif
  output logic          Ready,
  output logic          Busy,
  output logic [DW-1:0] Rd_Data,
  output logic          Rd_Valid,
  output logic [AW:0]   Count,
  output logic [3:0]    Cap_Mode
);

  localparam logic [AW:0] CNT_LAST_WR = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_LAST_RD = (AW+1)'(1);

`ifdef SAMPLE_CAPTURE_TRIGGER_EN
  localparam state_t ARM_STATE = ST_ARMED;
`else
  localparam state_t ARM_STATE = ST_CAPTURE;
`endif

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [3:0]    cap_mode_q;
  logic          rd_valid_q;
  logic          wr_en;
  logic          rd_en;
  logic          trig_hit;

`ifdef SAMPLE_CAPTURE_TRIGGER_EN
  logic [DW-1:0] prev_q;
  logic          primed_q;

  // The first strobe after Arm only primes prev_q; a hit needs a rising crossing.
  assign trig_hit = (state == ST_ARMED) && Enable && !Arm && primed_q &&
                    (prev_q < Trig_Level) && (Trig_Level <= Sample);

  always_ff @(posedge Fg_CLK) begin
    if (RESET || Arm) begin
      prev_q   <= '0;
      primed_q <= 1'b0;
    end else if ((state == ST_ARMED) && Enable) begin
      prev_q   <= Sample;
      primed_q <= 1'b1;
    end
  end
`else
  assign trig_hit = 1'b0;
`endif

  // Arm wins over any same-cycle strobe or read request.
  assign wr_en = ((state == ST_CAPTURE) && Enable && !Arm) || trig_hit;
  assign rd_en = (state == ST_READOUT) && Rd_En && !Arm;

  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (Arm) begin
      state_nxt = ARM_STATE;
    end else begin
      case (state)
        ST_CAPTURE: if (wr_en && (cnt == CNT_LAST_WR)) state_nxt = ST_READOUT;
        ST_READOUT: if (rd_en && (cnt == CNT_LAST_RD)) state_nxt = ST_IDLE;
`ifdef SAMPLE_CAPTURE_TRIGGER_EN
        ST_ARMED:   if (trig_hit) state_nxt = ST_CAPTURE;
`endif
        default:    state_nxt = state;
      endcase
    end
  end

  always_comb begin
    Busy  = (state == ST_CAPTURE);
`ifdef SAMPLE_CAPTURE_TRIGGER_EN
    Busy  = Busy || (state == ST_ARMED);
`endif
    Ready = (state == ST_READOUT);
  end

  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      cap_mode_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (Arm) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        cnt        <= '0;
        cap_mode_q <= Mode;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        cnt    <= cnt + 1'b1;
      end else if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        cnt    <= cnt - 1'b1;
      end
    end
  end

  sample_capture_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (Fg_CLK),
    .rst     (RESET),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (Sample),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (Rd_Data)
  );

  assign Count    = cnt;
  assign Cap_Mode = cap_mode_q;
  assign Rd_Valid = rd_valid_q;

endmodule

// File: tb/tb_sample_capture.sv
// Directed bench for sample_capture with DEPTH=8; expected values are hand-computed.
module tb_sample_capture;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          Fg_CLK = 1'b0;
  logic          RESET  = 1'b1;
  logic          Enable = 1'b0;
  logic [DW-1:0] Sample = '0;
  logic [3:0]    Mode   = '0;
  logic          Arm    = 1'b0;
  logic          Rd_En  = 1'b0;
`ifdef SAMPLE_CAPTURE_TRIGGER_EN
  logic [DW-1:0] Trig_Level = '0;
`endif
  logic          Ready;
  logic          Busy;
  logic [DW-1:0] Rd_Data;
  logic          Rd_Valid;
  logic [AW:0]   Count;
  logic [3:0]    Cap_Mode;

  int n_checks = 0;
  int n_fail   = 0;

  sample_capture #(.DW(DW), .DEPTH(DEPTH)) dut (
    .Fg_CLK     (Fg_CLK),
    .RESET      (RESET),
    .Enable     (Enable),
    .Sample     (Sample),
    .Mode       (Mode),
    .Arm        (Arm),
    .Rd_En      (Rd_En),
`ifdef SAMPLE_CAPTURE_TRIGGER_EN
    .Trig_Level (Trig_Level),
`endif
    .Ready      (Ready),
    .Busy       (Busy),
    .Rd_Data    (Rd_Data),
    .Rd_Valid   (Rd_Valid),
    .Count      (Count),
    .Cap_Mode   (Cap_Mode)
  );

  always #5 Fg_CLK = ~Fg_CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge Fg_CLK);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ready"}, 32'(Ready), 0);
    check({tag, "_busy"}, 32'(Busy), 0);
    check({tag, "_count"}, 32'(Count), 0);
    check({tag, "_rd_valid"}, 32'(Rd_Valid), 0);
    check({tag, "_rd_data"}, 32'(Rd_Data), 0);
    check({tag, "_cap_mode"}, 32'(Cap_Mode), 0);
  endtask

  initial begin
    tick();
    tick();
    RESET = 1'b0;
    tick();
    check_idle_zero("reset");

    // Capture 10..17; Rd_En held high before Ready must not produce reads.
    Mode = 4'd3;
    Arm  = 1'b1;
    tick();
    Arm  = 1'b0;
    Mode = 4'd2;
    check("arm_busy", 32'(Busy), 1);
    check("arm_ready", 32'(Ready), 0);
    check("arm_cap_mode", 32'(Cap_Mode), 3);
    for (int i = 0; i < 8; i++) begin
      Enable = 1'b1;
      Sample = DW'(10 + i);
      Rd_En  = 1'b1;
      tick();
      check("cap_count", 32'(Count), 32'(i + 1));
      check("cap_no_rd_valid", 32'(Rd_Valid), 0);
      if (i < 7) check("cap_busy", 32'(Busy), 1);
    end
    check("full_ready", 32'(Ready), 1);
    check("full_busy", 32'(Busy), 0);
    check("full_cap_mode", 32'(Cap_Mode), 3);

    // Strobes 9..12 after full are dropped.
    Rd_En = 1'b0;
    for (int i = 0; i < 4; i++) begin
      Sample = DW'(200 + i);
      tick();
      check("drop_count", 32'(Count), 8);
    end
    Enable = 1'b0;

    // Back-to-back reads, one result per cycle at 1-cycle latency.
    Rd_En = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rd_valid", 32'(Rd_Valid), 1);
      check("rd_data", 32'(Rd_Data), 32'(10 + k));
      check("rd_count", 32'(Count), 32'(7 - k));
      if (k < 7) check("rd_ready", 32'(Ready), 1);
    end
    check("drain_ready", 32'(Ready), 0);
    check("drain_busy", 32'(Busy), 0);
    tick();
    check("idle_rd_ignored", 32'(Rd_Valid), 0);
    check("idle_rd_hold", 32'(Rd_Data), 17);
    Rd_En = 1'b0;

    // Arm with a same-cycle Enable: 99 must not be stored.
    Mode   = 4'd1;
    Arm    = 1'b1;
    Enable = 1'b1;
    Sample = 8'd99;
    tick();
    Arm = 1'b0;
    check("arm2_count", 32'(Count), 0);
    for (int i = 1; i <= 8; i++) begin
      Sample = DW'(i);
      tick();
    end
    Enable = 1'b0;
    check("cap2_ready", 32'(Ready), 1);
    check("cap2_cap_mode", 32'(Cap_Mode), 1);
    Rd_En = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rd2_data", 32'(Rd_Data), 32'(k + 1));
    end
    Rd_En = 1'b0;

    // Arm during readout aborts it.
    Mode = 4'd4;
    Arm  = 1'b1;
    tick();
    Arm = 1'b0;
    check("abort_ready", 32'(Ready), 0);
    check("abort_count", 32'(Count), 0);
    check("abort_busy", 32'(Busy), 1);
    check("abort_cap_mode", 32'(Cap_Mode), 4);
    check("abort_rd_hold", 32'(Rd_Data), 3);

    // Reset mid-capture.
    Enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Sample = DW'(50 + i);
      tick();
    end
    check("mid_count", 32'(Count), 3);
    Enable = 1'b0;
    RESET  = 1'b1;
    Arm    = 1'b1;
    tick();
    RESET = 1'b0;
    Arm   = 1'b0;
    check_idle_zero("mid_reset");

`ifdef SAMPLE_CAPTURE_TRIGGER_EN
    // Rising crossing of 50 on the ramp 40,45,50,55,...
    Trig_Level = 8'd50;
    Arm        = 1'b1;
    tick();
    Arm = 1'b0;
    check("trig_armed_busy", 32'(Busy), 1);
    Enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Sample = DW'(40 + 5 * i);
      tick();
    end
    check("trig_hit_count", 32'(Count), 1);
    for (int i = 0; i < 7; i++) begin
      Sample = DW'(55 + 5 * i);
      tick();
    end
    Enable = 1'b0;
    check("trig_ready", 32'(Ready), 1);
    Rd_En = 1'b1;
    tick();
    Rd_En = 1'b0;
    check("trig_first", 32'(Rd_Data), 50);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
